// File: rtl/sqrt_rec_fn_to_raw_fn_iter.sv
// rtl/sqrt_rec_fn_to_raw_fn_iter.sv - iterative fp64 recFN square root producing an unrounded raw float
// Optional early special-case bypass: define SQRT_EARLY_SPECIAL_EN.
module sqrt_rec_fn_to_raw_fn_iter (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_in_valid,
  output logic        io_in_ready,
  input  logic [64:0] io_in_bits_a,
  input  logic [2:0]  io_in_bits_roundingMode,
  output logic        io_out_valid,
  input  logic        io_out_ready,
  output logic        io_out_invalidExc,
  output logic        io_out_isNaN,
  output logic        io_out_isInf,
  output logic        io_out_isZero,
  output logic        io_out_sign,
  output logic [12:0] io_out_sExp,
  output logic [55:0] io_out_sig,
  output logic [2:0]  io_out_roundingMode
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ITER = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state;
  logic [5:0]  cnt;
  logic [53:0] rad;
  logic [54:0] rem;
  logic [53:0] root;
  logic [12:0] normSExp;
  logic        spActive;
  logic        spInvalid;
  logic        spNaN;
  logic        spInf;
  logic        spZero;
  logic        spSign;
  logic [2:0]  capRm;

  // operand decode
  logic [11:0] inExp;
  logic [51:0] inFrac;
  logic        inSign;
  logic        inIsZero;
  logic        inSpecialExp;
  logic        inIsNaN;
  logic        inIsInf;
  logic        inSNaN;
  logic        dIsSpecial;
  logic        dNaN;
  logic        dInvalid;
  logic        dInf;
  logic        dZero;
  logic        dSign;
  logic [12:0] dSExp;
  logic [53:0] dRad;

  always_comb begin
    inExp        = io_in_bits_a[63:52];
    inFrac       = io_in_bits_a[51:0];
    inSign       = io_in_bits_a[64];
    inIsZero     = (inExp[11:9] == 3'b000);
    inSpecialExp = (inExp[11:10] == 2'b11);
    inIsNaN      = inSpecialExp & inExp[9];
    inIsInf      = inSpecialExp & ~inExp[9];
    inSNaN       = inIsNaN & ~inFrac[51];
    // negative non-zero operands (including -Inf) have no real root
    dIsSpecial   = inIsNaN | inIsInf | inIsZero | inSign;
    dNaN         = inIsNaN | (inSign & ~inIsZero);
    dInvalid     = inSNaN | (inSign & ~inIsZero & ~inIsNaN);
    dInf         = inIsInf & ~inSign;
    dZero        = inIsZero;
    dSign        = inIsZero & inSign;
    dSExp        = {2'b00, inExp[11:1]} + 13'd1024;
    // odd exponents pre-shift the radicand so halving the exponent is exact
    dRad         = inExp[0] ? {1'b1, inFrac, 1'b0} : {2'b01, inFrac};
  end

  // one restoring root digit per cycle, two radicand bits consumed per digit
  logic [56:0] remShift;
  logic [56:0] remDiff;
  logic [56:0] remNext;
  logic        digit;
  logic [53:0] rootNext;

  always_comb begin
    remShift = {rem, rad[53:52]};
    remDiff  = remShift - {1'b0, root, 2'b01};
    digit    = ~remDiff[56];
    remNext  = digit ? remDiff : remShift;
    rootNext = {root[52:0], digit};
  end

  logic        resInvalid;
  logic        resNaN;
  logic        resInf;
  logic        resZero;
  logic        resSign;
  logic [12:0] resSExp;
  logic [55:0] resSig;

  always_comb begin
    resInvalid = spActive & spInvalid;
    resNaN     = spActive & spNaN;
    resInf     = spActive & spInf;
    resZero    = spActive & spZero;
    resSign    = spActive & spSign;
    resSExp    = spActive ? 13'd0 : normSExp;
    resSig     = spActive ? 56'd0 : {1'b0, rootNext, |remNext};
  end

  assign io_in_ready  = (state == IDLE);
  assign io_out_valid = (state == DONE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state               <= IDLE;
      cnt                 <= 6'd0;
      rad                 <= 54'd0;
      rem                 <= 55'd0;
      root                <= 54'd0;
      normSExp            <= 13'd0;
      spActive            <= 1'b0;
      spInvalid           <= 1'b0;
      spNaN               <= 1'b0;
      spInf               <= 1'b0;
      spZero              <= 1'b0;
      spSign              <= 1'b0;
      capRm               <= 3'd0;
      io_out_invalidExc   <= 1'b0;
      io_out_isNaN        <= 1'b0;
      io_out_isInf        <= 1'b0;
      io_out_isZero       <= 1'b0;
      io_out_sign         <= 1'b0;
      io_out_sExp         <= 13'd0;
      io_out_sig          <= 56'd0;
      io_out_roundingMode <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (io_in_valid) begin
            capRm     <= io_in_bits_roundingMode;
            normSExp  <= dSExp;
            rad       <= dRad;
            rem       <= 55'd0;
            root      <= 54'd0;
            cnt       <= 6'd53;
            spActive  <= dIsSpecial;
            spInvalid <= dInvalid;
            spNaN     <= dNaN;
            spInf     <= dInf;
            spZero    <= dZero;
            spSign    <= dSign;
`ifdef SQRT_EARLY_SPECIAL_EN
            if (dIsSpecial) begin
              io_out_invalidExc   <= dInvalid;
              io_out_isNaN        <= dNaN;
              io_out_isInf        <= dInf;
              io_out_isZero       <= dZero;
              io_out_sign         <= dSign;
              io_out_sExp         <= 13'd0;
              io_out_sig          <= 56'd0;
              io_out_roundingMode <= io_in_bits_roundingMode;
              state               <= DONE;
            end else begin
              state <= ITER;
            end
`else
            state <= ITER;
`endif
          end
        end
        ITER: begin
          rad  <= {rad[51:0], 2'b00};
          rem  <= remNext[54:0];
          root <= rootNext;
          cnt  <= cnt - 6'd1;
          if (cnt == 6'd0) begin
            io_out_invalidExc   <= resInvalid;
            io_out_isNaN        <= resNaN;
            io_out_isInf        <= resInf;
            io_out_isZero       <= resZero;
            io_out_sign         <= resSign;
            io_out_sExp         <= resSExp;
            io_out_sig          <= resSig;
            io_out_roundingMode <= capRm;
            state               <= DONE;
          end
        end
        DONE: begin
          if (io_out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
